// File: rtl/serial_tx_if.sv
// serial_tx_if: byte handshake and serial line status between a producer and serial_tx.
interface serial_tx_if;
  logic       i_Tx_DV;
  logic [7:0] i_Tx_Byte;
  logic       o_Tx_Ready;
  logic       o_Tx_Serial;
  logic       o_Tx_Active;
  logic       o_Tx_Done;
  logic       o_Tx_Drop;
  modport master (
    output i_Tx_DV, i_Tx_Byte,
    input  o_Tx_Ready, o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Tx_Drop
  );
  modport slave (
    input  i_Tx_DV, i_Tx_Byte,
    output o_Tx_Ready, o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Tx_Drop
  );
endinterface

// File: rtl/serial_tx.sv
// serial_tx: 8N1 UART transmitter fed by a small byte FIFO with a valid/ready handshake.
module serial_tx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIFO_DEPTH   = 4
) (
  input logic        i_Clock,
  input logic        i_Reset,
  serial_tx_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} state_t;
  state_t        r_state, w_next;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_count;
  logic [7:0]    r_shift;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [2:0]    r_idx, w_idx;
  logic          r_serial, r_active, r_done, r_drop;
  logic          w_push, w_pop, w_last, w_line, w_active, w_done;
  assign bus.o_Tx_Ready  = r_count < (AW+1)'(FIFO_DEPTH);
  assign bus.o_Tx_Serial = r_serial;
  assign bus.o_Tx_Active = r_active;
  assign bus.o_Tx_Done   = r_done;
  assign bus.o_Tx_Drop   = r_drop;
  assign w_push = bus.i_Tx_DV & bus.o_Tx_Ready;
  assign w_last = r_cnt == CW'(CLKS_PER_BIT - 1);
  always_ff @(posedge i_Clock or posedge i_Reset)
    if (i_Reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_cnt  = w_last ? '0 : r_cnt + CW'(1);
    w_idx  = r_idx;
    w_pop  = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt  = '0;
        w_pop  = r_count != '0;
        w_next = w_pop ? START : IDLE;
      end
      START: begin
        w_idx  = '0;
        w_next = w_last ? DATA : START;
      end
      DATA: begin
        w_idx  = (w_last && r_idx != 3'd7) ? r_idx + 3'd1 : r_idx;
        w_next = (w_last && r_idx == 3'd7) ? STOP : DATA;
      end
      STOP:    w_next = w_last ? CLEANUP : STOP;
      CLEANUP: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // Outputs are decoded from the next state so the registered line moves on the same edge as the state.
  always_comb begin
    w_line   = (w_next == START) ? 1'b0 : (w_next == DATA) ? r_shift[w_idx] : 1'b1;
    w_active = w_next inside {START, DATA, STOP};
    w_done   = w_next == CLEANUP;
  end
  always_ff @(posedge i_Clock or posedge i_Reset)
    if (i_Reset) begin
      r_wp     <= '0;
      r_rp     <= '0;
      r_count  <= '0;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_serial <= 1'b1;
      r_active <= 1'b0;
      r_done   <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      r_wp     <= r_wp + AW'(w_push);
      r_rp     <= r_rp + AW'(w_pop);
      r_count  <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_cnt    <= w_cnt;
      r_idx    <= w_idx;
      r_serial <= w_line;
      r_active <= w_active;
      r_done   <= w_done;
      r_drop   <= bus.i_Tx_DV & ~bus.o_Tx_Ready;
    end
  always_ff @(posedge i_Clock) begin
    if (w_push) r_mem[r_wp] <= bus.i_Tx_Byte;
    if (w_pop) r_shift <= r_mem[r_rp];
  end
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed and random stimulus for serial_tx, checked cycle by cycle against a frame-timeline model.
module tb_serial_tx;
  localparam int CPB    = 4;
  localparam int DEPTH  = 4;
  localparam int FRAME  = 10 * CPB;
  localparam int PERIOD = FRAME + 2;
  localparam int HMAX   = 8192;
  logic clk = 1'b0;
  logic rst;
  serial_tx_if bus();
  serial_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (.i_Clock(clk), .i_Reset(rst), .bus(bus));
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  int cyc = 0;
  bit hist [HMAX];
  bit acth [HMAX];
  bit doneh [HMAX];
  logic [7:0] m_q [$];
  logic [7:0] sent [$];
  logic [7:0] rx_q [$];
  int st_q [$];
  logic [7:0] m_cur = '0;
  int m_p = -1000, m_free = 0;
  bit e_drop = 1'b0;
  logic [7:0] burst [4] = '{8'h30, 8'h31, 8'h32, 8'h55};
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask
  function automatic bit fbit(logic [7:0] b, int j);
    return (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : b[j-1];
  endfunction
  task automatic m_reset();
    m_q.delete();
    m_p = -1000;
    m_free = 0;
    e_drop = 1'b0;
  endtask
  // Model: a popped byte owns the line for FRAME cycles; the next pop is PERIOD edges later.
  task automatic step();
    bit rp;
    int k;
    @(posedge clk);
    cyc++;
    if (rst) m_reset();
    else begin
      rp = m_q.size() < DEPTH;
      if (m_q.size() > 0 && cyc >= m_free) begin
        m_cur = m_q.pop_front();
        m_p = cyc;
        m_free = cyc + PERIOD;
        sent.push_back(m_cur);
      end
      if (bus.i_Tx_DV && rp) m_q.push_back(bus.i_Tx_Byte);
      e_drop = bus.i_Tx_DV && !rp;
    end
    #1;
    k = cyc - m_p;
    if (cyc < HMAX) begin
      hist[cyc]  = bus.o_Tx_Serial;
      acth[cyc]  = bus.o_Tx_Active;
      doneh[cyc] = bus.o_Tx_Done;
    end
    chk("line", bus.o_Tx_Serial, (k >= 0 && k < FRAME) ? fbit(m_cur, k / CPB) : 1'b1);
    chk("active", bus.o_Tx_Active, k >= 0 && k < FRAME);
    chk("done", bus.o_Tx_Done, k == FRAME);
    chk("ready", bus.o_Tx_Ready, m_q.size() < DEPTH);
    chk("drop", bus.o_Tx_Drop, e_drop);
  endtask
  task automatic push(logic [7:0] b);
    bus.i_Tx_DV = 1'b1;
    bus.i_Tx_Byte = b;
    step();
    bus.i_Tx_DV = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while ((m_q.size() > 0 || cyc < m_p + PERIOD) && n < 3000) begin
      step();
      n++;
    end
    chk("drain_bound", n < 3000, 1);
  endtask
  // Bench UART receiver: find falling edges on the recorded line and sample mid-bit.
  task automatic decode(int from, int to);
    int i = from;
    logic [7:0] b;
    rx_q.delete();
    st_q.delete();
    while (i + FRAME <= to + 1) begin
      if (hist[i-1] && !hist[i]) begin
        for (int j = 0; j < 8; j++) b[j] = hist[i + CPB * (j + 1) + CPB / 2];
        rx_q.push_back(b);
        st_q.push_back(i);
        i += FRAME;
      end else i++;
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
  initial begin
    int acc, s, n, bi, sent0;
    rst = 1'b0;
    bus.i_Tx_DV = 1'b0;
    bus.i_Tx_Byte = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_serial", bus.o_Tx_Serial, 1);
    chk("rst_ready", bus.o_Tx_Ready, 1);
    chk("rst_active", bus.o_Tx_Active, 0);
    chk("rst_done", bus.o_Tx_Done, 0);
    chk("rst_drop", bus.o_Tx_Drop, 0);
    m_reset();
    step();
    step();
    rst = 1'b0;
    s = cyc;
    repeat (20) step();
    n = 0;
    for (int i = s + 1; i <= cyc; i++) n += int'(hist[i]);
    chk("idle_line_high", n, 20);
    push(8'h31);
    acc = cyc;
    repeat (34) step();
    bus.i_Tx_DV = 1'b1;
    foreach (burst[i]) begin
      bus.i_Tx_Byte = burst[i];
      step();
    end
    chk("burst_ready_low", bus.o_Tx_Ready, 0);
    bus.i_Tx_Byte = 8'hAA;
    step();
    bus.i_Tx_DV = 1'b0;
    chk("burst_drop", bus.o_Tx_Drop, 1);
    drain();
    n = 0;
    for (int j = 0; j < FRAME; j++) n += int'(hist[acc + 1 + j] != fbit(8'h31, j / CPB));
    chk("single_wave_err", n, 0);
    n = 0;
    for (int i = acc; i <= acc + 42; i++) n += int'(acth[i]);
    chk("single_active_cycles", n, FRAME);
    n = 0;
    for (int i = acc; i <= acc + 42; i++) n += int'(doneh[i]);
    chk("single_done_pulses", n, 1);
    decode(acc, acc + 42);
    chk("single_rx_count", rx_q.size(), 1);
    chk("single_rx_byte", rx_q[0], 8'h31);
    decode(acc + 42, cyc);
    chk("burst_rx_count", rx_q.size(), 4);
    foreach (rx_q[i]) chk("burst_rx_byte", rx_q[i], burst[i]);
    for (int i = 0; i + 1 < st_q.size(); i++) chk("burst_high_gap", st_q[i+1] - (st_q[i] + 9 * CPB), CPB + 2);
    n = 0;
    for (int i = acc + 43; i <= cyc; i++) n += int'(doneh[i]);
    chk("burst_done_pulses", n, 4);
    s = cyc;
    push(8'hA0);
    bus.i_Tx_DV = 1'b1;
    for (int i = 1; i < 5; i++) begin
      bus.i_Tx_Byte = 8'hA0 + 8'(i);
      step();
    end
    bus.i_Tx_DV = 1'b0;
    chk("full_ready_low", bus.o_Tx_Ready, 0);
    while (cyc < m_free - 1) step();
    bus.i_Tx_DV = 1'b1;
    bus.i_Tx_Byte = 8'hA5;
    step();
    chk("full_pop_edge_drop", bus.o_Tx_Drop, 1);
    chk("full_pop_edge_ready", bus.o_Tx_Ready, 1);
    step();
    bus.i_Tx_DV = 1'b0;
    chk("full_next_edge_drop", bus.o_Tx_Drop, 0);
    chk("full_next_edge_ready", bus.o_Tx_Ready, 0);
    drain();
    decode(s, cyc);
    chk("full_rx_count", rx_q.size(), 6);
    chk("full_rx_last", rx_q[5], 8'hA5);
    push(8'h00);
    acc = cyc;
    push(8'h11);
    push(8'h22);
    while (cyc < acc + 18) step();
    rst = 1'b1;
    #1;
    chk("midrst_line", bus.o_Tx_Serial, 1);
    chk("midrst_active", bus.o_Tx_Active, 0);
    chk("midrst_ready", bus.o_Tx_Ready, 1);
    m_reset();
    step();
    rst = 1'b0;
    s = cyc;
    repeat (50) step();
    n = 0;
    for (int i = s + 1; i <= cyc; i++) n += int'(hist[i]);
    chk("midrst_fifo_empty", n, 50);
    s = cyc;
    push(8'h32);
    drain();
    decode(s, cyc);
    chk("midrst_rx_count", rx_q.size(), 1);
    chk("midrst_rx_byte", rx_q[0], 8'h32);
    s = cyc;
    sent0 = 0;
    for (int i = s + 1; i <= cyc; i++) sent0 += 0;
    bi = 0;
    n = 0;
    acc = 0;
    while (bi < 10 && n < 2000) begin
      bus.i_Tx_DV = bus.o_Tx_Ready;
      bus.i_Tx_Byte = 8'(bi);
      step();
      acc += int'(bus.o_Tx_Drop === 1'b1);
      if (bus.i_Tx_DV) bi++;
      n++;
    end
    bus.i_Tx_DV = 1'b0;
    chk("wrap_push_bound", bi, 10);
    drain();
    decode(s, cyc);
    chk("wrap_rx_count", rx_q.size(), 10);
    foreach (rx_q[i]) chk("wrap_rx_byte", rx_q[i], 8'(i));
    chk("wrap_no_drop", acc, 0);
    s = cyc;
    sent0 = sent.size();
    repeat (600) begin
      bus.i_Tx_DV = ($urandom_range(0, 3) == 0);
      bus.i_Tx_Byte = 8'($urandom);
      step();
    end
    bus.i_Tx_DV = 1'b0;
    drain();
    decode(s, cyc);
    chk("rand_rx_count", rx_q.size(), sent.size() - sent0);
    foreach (rx_q[i]) chk("rand_rx_byte", rx_q[i], sent[sent0 + i]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
